// File: rtl/sram_dp_be.sv
// Simple dual-port synchronous SRAM with byte enables, write-first bypass and post-reset hardware clear.
// Optional per-byte even parity storage and checking is enabled by defining SRAM_DP_PARITY_EN.
module sram_dp_be #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NBYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [NBYTES-1:0] wr_be,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic [ADDR_W-1:0] rd_add,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
`ifdef SRAM_DP_PARITY_EN
  ,
  input  logic              par_inject,
  output logic              parity_err
`endif
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_q;

  logic wr_ok;
  logic rd_go;
  logic rd_in;
  logic collide;

  // Handshake: a request is taken on an edge where it is high, busy is low and
  // reset is released; there is no back-pressure, so anything else is dropped.
  assign wr_ok   = rst_n & ~busy_q & wr & ({1'b0, wr_add} < DEPTH_C);
  assign rd_go   = rst_n & ~busy_q & rd;
  assign rd_in   = ({1'b0, rd_add} < DEPTH_C);
  assign collide = wr_ok & rd_go & rd_in & (wr_add == rd_add);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      if (ptr_q == LAST_C) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
    end
  end

  // Storage array has no reset; it is zeroed by the clear walk instead.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) mem_q[wr_add][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  // Write-first: enabled bytes of a same-address write bypass the array.
  always_comb begin
    rd_data_d = '0;
    if (rd_in) begin
      for (int i = 0; i < NBYTES; i++) begin
        rd_data_d[8*i +: 8] = (collide && wr_be[i]) ? data_in[8*i +: 8]
                                                    : mem_q[rd_add][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) data_out_q <= rd_data_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

`ifdef SRAM_DP_PARITY_EN
  logic [NBYTES-1:0] par_q [DEPTH];
  logic [NBYTES-1:0] wr_par;
  logic              par_err_d;
  logic              parity_err_q;

  always_comb begin
    wr_par = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wr_par[i] = (^data_in[8*i +: 8]) ^ par_inject;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state_q == CLEAR) begin
      par_q[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) par_q[wr_add][i] <= wr_par[i];
      end
    end
  end

  always_comb begin
    par_err_d = 1'b0;
    if (rd_in) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (collide && wr_be[i]) begin
          par_err_d = par_err_d | ((^rd_data_d[8*i +: 8]) ^ wr_par[i]);
        end else begin
          par_err_d = par_err_d | ((^rd_data_d[8*i +: 8]) ^ par_q[rd_add][i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= rd_go & par_err_d;
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
Parametrised simple dual-port synchronous SRAM: one write port and one read port, both on the same clock, with per-byte write enables. It is the generalised successor of the team's 8x8 single-port SRAM. Adds configurable width and depth, a read-valid strobe, write-first bypass on address collisions, and a hardware clear sequence after reset. It sits behind datapath blocks as scratch storage, where deterministic post-reset contents are required.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8 and at least 8.
DEPTH, 8, number of words; need not be a power of 2.
ADDR_W, $clog2(DEPTH) (minimum 1), address width in bits.
NBYTES, DATA_W/8, derived; number of byte lanes; not to be overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
wr  input  1  write request.
wr_add  input  ADDR_W  write address.
wr_be  input  NBYTES  byte enables; bit i covers data_in[8i+7:8i].
data_in  input  DATA_W  write data.
rd  input  1  read request.
rd_add  input  ADDR_W  read address.
data_out  output  DATA_W  registered read data.
rd_valid  output  1  high for one cycle when data_out carries data from an accepted read.
busy  output  1  high while reset is active or the clear sequence is running; wr and rd are ignored while high.

Behaviour:
- Both clock and reset are decided: one clock, clk; reset is synchronous and active-low, rst_n. All state changes on the rising edge of clk.
- Reset (rst_n=0 at an edge): data_out=0, rd_valid=0, busy=1, FSM=CLEAR, clear pointer=0. Memory contents are not touched during reset itself.
- FSM states: CLEAR, IDLE.
- CLEAR, each edge with rst_n=1:
  - Write all-zero to mem[ptr], then ptr++.
  - At ptr==DEPTH-1, write and move to IDLE.
  - Net effect: busy stays 1 for exactly DEPTH edges after rst_n rises; the first accepted access is on the edge after busy reads 0.
- Reset asserted mid-CLEAR: ptr returns to 0 and the full clear sequence restarts.
- IDLE: busy=0. No return to CLEAR except through reset.
- Write, accepted when busy=0, wr=1 and wr_add<DEPTH:
  - For each i with wr_be[i]=1, byte i of mem[wr_add] takes data_in byte i.
  - Other bytes are unchanged.
  - wr_be=0 means no change.
- Read, accepted when busy=0, rd=1 and rd_add<DEPTH:
  - One-cycle latency: data_out=mem[rd_add] and rd_valid=1 on the next edge.
- Read with rd_add>=DEPTH (non-power-of-2 DEPTH): data_out=0, rd_valid=1.
- Write with wr_add>=DEPTH: dropped silently.
- No read accepted: rd_valid=0 and data_out holds its previous value. No high-impedance drive; the output is never Z.
- Same-address read and write in one cycle: write-first.
  - Enabled bytes return the new data_in bytes.
  - Disabled bytes return the old memory bytes.
- Different addresses in the same cycle: both complete independently.
- Requests arriving while busy=1 are dropped; no queuing.

Optional Feature:
Macro SRAM_DP_PARITY_EN.
- When defined:
  - Store one even-parity bit per byte lane alongside the data.
  - Add output parity_err (1 bit), registered, aligned with rd_valid. It is high when any read byte's stored parity mismatches.
  - Add input par_inject (1 bit). When set on an accepted write, the stored parity of every enabled byte is inverted, for test purposes.
  - Clear writes correct parity (0 for zero bytes).
  - Bypass reads compute parity on the bypassed bytes as stored.
  - parity_err resets to 0 and is 0 whenever rd_valid=0.
- When undefined: no parity storage, and neither extra port exists.

Test Plan:
- Reset, DATA_W=16, DEPTH=5: rst_n low 3 cycles then high -> busy=1 for exactly 5 edges. Then read every address -> all 0x0000 with rd_valid=1.
- Write addr 2 = 0xA5C3, be=2'b11, next cycle read addr 2 -> data_out=0xA5C3 one cycle later. Then write addr 2 = 0x1234, be=2'b01, read -> 0xA534.
- Same-cycle write addr 3 = 0xBEEF, be=2'b10, with read addr 3 (previously 0x0000) -> data_out=0xBE00. A later read of addr 3 -> 0xBE00.
- wr=1 and rd=1 asserted during busy -> rd_valid stays 0 and memory unchanged. Read of addr 6 (>=DEPTH) -> data_out=0, rd_valid=1. Write to addr 7 -> no effect.
- Reset reasserted at clear edge 2 of 5, then released -> busy high 5 more edges. Memory previously written with 0xFFFF reads 0x0000 everywhere.
- SRAM_DP_PARITY_EN: write addr 1 = 0x00FF with par_inject=1, be=2'b01, then read -> data_out=0x00FF, parity_err=1. Clean write and read of the same address -> parity_err=0.
